// File: rtl/vx_mem_vec_serializer_if.sv
// rtl/vx_mem_vec_serializer_if.sv - vector request/response and scalar memory bus bundle
// Optional per-byte write enables are compiled in with VX_MEM_VSER_BYTEEN_EN.
interface vx_mem_vec_serializer_if #(
    parameter int DATA_SIZE  = 4,
    parameter int VLEN       = 256,
    parameter int TAG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 30
);
    localparam int DW        = DATA_SIZE * 8;
    localparam int BEATS     = VLEN / DW;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                          vreq_valid;
    logic                          vreq_rw;
    logic [ADDR_WIDTH-1:0]         vreq_addr;
    logic [VLEN-1:0]               vreq_vdata;
    logic [TAG_WIDTH-1:0]          vreq_tag;
`ifdef VX_MEM_VSER_BYTEEN_EN
    logic [VLEN/8-1:0]             vreq_vbyteen;
`endif
    logic                          vreq_ready;
    logic                          vrsp_valid;
    logic [VLEN-1:0]               vrsp_vdata;
    logic [TAG_WIDTH-1:0]          vrsp_tag;
    logic                          vrsp_ready;
    logic                          mem_req_valid;
    logic                          mem_req_rw;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic [DW-1:0]                 mem_req_data;
    logic [DATA_SIZE-1:0]          mem_req_byteen;
    logic [TAG_WIDTH+BEAT_BITS-1:0] mem_req_tag;
    logic                          mem_req_ready;
    logic                          mem_rsp_valid;
    logic [DW-1:0]                 mem_rsp_data;
    logic [TAG_WIDTH+BEAT_BITS-1:0] mem_rsp_tag;
    logic                          mem_rsp_ready;

    modport master (
`ifdef VX_MEM_VSER_BYTEEN_EN
        output vreq_vbyteen,
`endif
        output vreq_valid, vreq_rw, vreq_addr, vreq_vdata, vreq_tag,
        input  vreq_ready,
        input  vrsp_valid, vrsp_vdata, vrsp_tag,
        output vrsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );

    modport slave (
`ifdef VX_MEM_VSER_BYTEEN_EN
        input  vreq_vbyteen,
`endif
        input  vreq_valid, vreq_rw, vreq_addr, vreq_vdata, vreq_tag,
        output vreq_ready,
        output vrsp_valid, vrsp_vdata, vrsp_tag,
        input  vrsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_vec_serializer.sv
// rtl/vx_mem_vec_serializer.sv - splits vector memory requests into scalar beats and gathers read beats
// Define VX_MEM_VSER_BYTEEN_EN to add per-byte write enables with all-zero beat skipping.
module vx_mem_vec_serializer #(
    parameter int DATA_SIZE  = 4,
    parameter int VLEN       = 256,
    parameter int TAG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 30
) (
    input logic                     clk,
    input logic                     reset,
    vx_mem_vec_serializer_if.slave  bus
);
    localparam int DW        = DATA_SIZE * 8;
    localparam int BEATS     = VLEN / DW;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
    localparam logic [BEATS-1:0]     FULL_MASK = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t                 state;
    logic                   rw_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [VLEN-1:0]        vdata_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [BEAT_BITS-1:0]   beat;
    logic [BEATS-1:0]       mask;
`ifdef VX_MEM_VSER_BYTEEN_EN
    logic [VLEN/8-1:0]      vbyteen_q;
`endif

    logic                   req_fire, advance, last_beat, rsp_keep;
    logic [BEAT_BITS-1:0]   beat_inc, rsp_slot;
    logic [BEATS-1:0]       mask_next;
    logic                   skip_first, skip_next;
    logic [DATA_SIZE-1:0]   byteen_first, byteen_next;

    always_comb begin
        req_fire  = bus.mem_req_valid & bus.mem_req_ready;
        // A skipped write beat shows up as ISSUE with mem_req_valid low and still advances.
        advance   = (state == ISSUE) && (req_fire || !bus.mem_req_valid);
        last_beat = (beat == LAST_BEAT);
        beat_inc  = beat + BEAT_BITS'(1);
        rsp_slot  = bus.mem_rsp_tag[BEAT_BITS-1:0];
        rsp_keep  = bus.mem_rsp_valid && bus.mem_rsp_ready && !rw_q
                    && (state == ISSUE || state == WAIT_RSP)
                    && (bus.mem_rsp_tag[TAG_WIDTH+BEAT_BITS-1:BEAT_BITS] == tag_q)
                    && (rsp_slot <= LAST_BEAT) && !mask[rsp_slot];
        mask_next = mask;
        if (rsp_keep)
            mask_next[rsp_slot] = 1'b1;
`ifdef VX_MEM_VSER_BYTEEN_EN
        byteen_first = bus.vreq_rw ? bus.vreq_vbyteen[DATA_SIZE-1:0] : '1;
        byteen_next  = rw_q ? vbyteen_q[beat_inc*DATA_SIZE +: DATA_SIZE] : '1;
        skip_first   = (byteen_first == '0);
        skip_next    = (byteen_next == '0);
`else
        byteen_first = '1;
        byteen_next  = '1;
        skip_first   = 1'b0;
        skip_next    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            rw_q               <= 1'b0;
            addr_q             <= '0;
            vdata_q            <= '0;
            tag_q              <= '0;
            beat               <= '0;
            mask               <= '0;
`ifdef VX_MEM_VSER_BYTEEN_EN
            vbyteen_q          <= '0;
`endif
            bus.vreq_ready     <= 1'b1;
            bus.vrsp_valid     <= 1'b0;
            bus.vrsp_vdata     <= '0;
            bus.vrsp_tag       <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_rw     <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_data   <= '0;
            bus.mem_req_byteen <= '0;
            bus.mem_req_tag    <= '0;
            bus.mem_rsp_ready  <= 1'b1;
        end else begin
            if (rsp_keep) begin
                bus.vrsp_vdata[rsp_slot*DW +: DW] <= bus.mem_rsp_data;
                mask                              <= mask_next;
            end
            case (state)
                IDLE: if (bus.vreq_valid) begin
                    rw_q               <= bus.vreq_rw;
                    addr_q             <= bus.vreq_addr;
                    vdata_q            <= bus.vreq_vdata;
                    tag_q              <= bus.vreq_tag;
`ifdef VX_MEM_VSER_BYTEEN_EN
                    vbyteen_q          <= bus.vreq_vbyteen;
`endif
                    beat               <= '0;
                    mask               <= '0;
                    bus.vreq_ready     <= 1'b0;
                    bus.mem_req_valid  <= !skip_first;
                    bus.mem_req_rw     <= bus.vreq_rw;
                    bus.mem_req_addr   <= bus.vreq_addr;
                    bus.mem_req_data   <= bus.vreq_vdata[DW-1:0];
                    bus.mem_req_byteen <= byteen_first;
                    bus.mem_req_tag    <= {bus.vreq_tag, {BEAT_BITS{1'b0}}};
                    state              <= ISSUE;
                end
                ISSUE: if (advance) begin
                    if (last_beat) begin
                        bus.mem_req_valid <= 1'b0;
                        if (rw_q) begin
                            bus.vreq_ready <= 1'b1;
                            state          <= IDLE;
                        end else if (mask_next == FULL_MASK) begin
                            bus.vrsp_valid    <= 1'b1;
                            bus.vrsp_tag      <= tag_q;
                            bus.mem_rsp_ready <= 1'b0;
                            state             <= RESP;
                        end else begin
                            state <= WAIT_RSP;
                        end
                    end else begin
                        beat               <= beat_inc;
                        bus.mem_req_valid  <= !skip_next;
                        bus.mem_req_addr   <= addr_q + ADDR_WIDTH'(beat_inc);
                        bus.mem_req_data   <= vdata_q[beat_inc*DW +: DW];
                        bus.mem_req_byteen <= byteen_next;
                        bus.mem_req_tag    <= {tag_q, beat_inc};
                    end
                end
                WAIT_RSP: if (mask_next == FULL_MASK) begin
                    bus.vrsp_valid    <= 1'b1;
                    bus.vrsp_tag      <= tag_q;
                    bus.mem_rsp_ready <= 1'b0;
                    state             <= RESP;
                end
                RESP: if (bus.vrsp_ready) begin
                    bus.vrsp_valid    <= 1'b0;
                    bus.vreq_ready    <= 1'b1;
                    bus.mem_rsp_ready <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_mem_vec_serializer.sv
// tb/tb_vx_mem_vec_serializer.sv - scoreboard bench for the vector-to-scalar memory serializer
module tb_vx_mem_vec_serializer;
    localparam int DATA_SIZE = 4, VLEN = 256, TAG_WIDTH = 8, ADDR_WIDTH = 30;
    localparam int DW = 32, BEATS = 8;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
        logic [10:0] tag;
    } req_t;
    typedef struct {
        logic [7:0]      tag;
        logic [VLEN-1:0] vdata;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0, failures = 0, mem_hs = 0;
    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t mreq;
    rsp_t mrsp;

    always #5 clk = ~clk;

    vx_mem_vec_serializer_if #(.DATA_SIZE(DATA_SIZE), .VLEN(VLEN), .TAG_WIDTH(TAG_WIDTH),
                               .ADDR_WIDTH(ADDR_WIDTH)) bus ();
    vx_mem_vec_serializer #(.DATA_SIZE(DATA_SIZE), .VLEN(VLEN), .TAG_WIDTH(TAG_WIDTH),
                            .ADDR_WIDTH(ADDR_WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every presented beat / response is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.mem_req_valid) begin
            if (exp_req.size() == 0) begin
                check("mem_req_unexpected", bus.mem_req_valid, 0);
            end else begin
                mreq = exp_req[0];
                check("mem_req_rw", bus.mem_req_rw, mreq.rw);
                check("mem_req_addr", bus.mem_req_addr, mreq.addr);
                check("mem_req_data", bus.mem_req_data, mreq.data);
                check("mem_req_byteen", bus.mem_req_byteen, mreq.byteen);
                check("mem_req_tag", bus.mem_req_tag, mreq.tag);
                if (bus.mem_req_ready) begin
                    void'(exp_req.pop_front());
                    mem_hs++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.vrsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("vrsp_unexpected", bus.vrsp_valid, 0);
            end else begin
                mrsp = exp_rsp[0];
                check("vrsp_tag", bus.vrsp_tag, mrsp.tag);
                check("vrsp_vdata", bus.vrsp_vdata, mrsp.vdata);
                check("resp_vreq_ready", bus.vreq_ready, 0);
                check("resp_mem_rsp_ready", bus.mem_rsp_ready, 0);
                if (bus.vrsp_ready) void'(exp_rsp.pop_front());
            end
        end
    end

    function automatic logic [VLEN-1:0] mkvec(input logic [31:0] base, input logic [31:0] step);
        logic [VLEN-1:0] v;
        for (int i = 0; i < BEATS; i++) v[i*DW +: DW] = base + step * 32'(i);
        return v;
    endfunction

    task automatic push_reqs(input logic rw, input logic [29:0] addr, input logic [VLEN-1:0] vd,
                             input logic [7:0] tag, input logic [VLEN/8-1:0] vbe);
        req_t r;
        for (int i = 0; i < BEATS; i++) begin
            r.rw = rw;
            r.addr = addr + 30'(i);
            r.data = vd[i*DW +: DW];
            r.tag = {tag, 3'(i)};
            r.byteen = (vbe == '0 && 1'b0) ? 4'h0 : 4'hF;
`ifdef VX_MEM_VSER_BYTEEN_EN
            if (rw) r.byteen = vbe[i*4 +: 4];
            if (rw && r.byteen == 4'h0) continue;
`endif
            exp_req.push_back(r);
        end
    endtask

    task automatic send_vreq(input logic rw, input logic [29:0] addr, input logic [VLEN-1:0] vd,
                             input logic [7:0] tag, input logic [VLEN/8-1:0] vbe);
        push_reqs(rw, addr, vd, tag, vbe);
        bus.vreq_valid = 1'b1;
        bus.vreq_rw = rw;
        bus.vreq_addr = addr;
        bus.vreq_vdata = vd;
        bus.vreq_tag = tag;
`ifdef VX_MEM_VSER_BYTEEN_EN
        bus.vreq_vbyteen = vbe;
`endif
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.vreq_ready) break;
            @(posedge clk); #1;
        end
        check("vreq_accept", bus.vreq_ready, 1);
        @(posedge clk); #1;
        bus.vreq_valid = 1'b0;
    endtask

    // Counts cycles from the one after acceptance until vreq_ready is seen high again.
    task automatic wait_vreq_ready(output int n, input bit bp);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.vreq_ready) break;
            @(posedge clk); #1;
            if (bp) bus.mem_req_ready = ~bus.mem_req_ready;
            n++;
        end
        check("vreq_ready_return", bus.vreq_ready, 1);
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b1;
    endtask

    task automatic wait_beats_done();
        for (int k = 0; k < 100 && exp_req.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("beats_done", exp_req.size(), 0);
    endtask

    task automatic send_rsp(input logic [2:0] idx, input logic [31:0] data, input logic [7:0] tagu);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag = {tagu, idx};
        bus.mem_rsp_data = data;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.mem_rsp_ready) break;
            @(posedge clk); #1;
        end
        check("mem_rsp_ready", bus.mem_rsp_ready, 1);
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic wait_rsp_done();
        for (int k = 0; k < 100 && exp_rsp.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("vrsp_done", exp_rsp.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h0;
        logic [2:0] order[8];
        rsp_t r;
        reset = 1'b1;
        bus.vreq_valid = 1'b0; bus.vreq_rw = 1'b0; bus.vreq_addr = '0;
        bus.vreq_vdata = '0; bus.vreq_tag = '0;
`ifdef VX_MEM_VSER_BYTEEN_EN
        bus.vreq_vbyteen = '0;
`endif
        bus.vrsp_ready = 1'b1; bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.mem_rsp_tag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_vreq_ready", bus.vreq_ready, 1);
        check("rst_vrsp_valid", bus.vrsp_valid, 0);
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_mem_rsp_ready", bus.mem_rsp_ready, 1);
        check("rst_mem_req_addr", bus.mem_req_addr, 0);
        check("rst_vrsp_vdata", bus.vrsp_vdata, 0);
        @(posedge clk); #1;

        // Plain write: 8 beats, back to IDLE 9 cycles after acceptance.
        send_vreq(1'b1, 30'h100, mkvec(32'hA0, 1), 8'h12, '1);
        wait_vreq_ready(n, 1'b0);
        check("write_latency", n, 9);
        check("write_beats_left", exp_req.size(), 0);

        // Read with out-of-order responses.
        r.tag = 8'h3C; r.vdata = mkvec(32'hB0, 1); exp_rsp.push_back(r);
        send_vreq(1'b0, 30'h200, '0, 8'h3C, '1);
        wait_beats_done();
        order = '{3'd7, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd3};
        for (int i = 0; i < 7; i++) send_rsp(order[i], 32'hB0 + 32'(order[i]), 8'h3C);
        @(negedge clk);
        check("vrsp_early", bus.vrsp_valid, 0);
        @(posedge clk); #1;
        send_rsp(order[7], 32'hB0 + 32'(order[7]), 8'h3C);
        @(negedge clk);
        check("vrsp_latency", bus.vrsp_valid, 1);
        wait_rsp_done();

        // Write under 1010 backpressure.
        h0 = mem_hs;
        send_vreq(1'b1, 30'h180, mkvec(32'h5000, 32'h111), 8'h21, '1);
        wait_vreq_ready(n, 1'b1);
        check("bp_handshakes", mem_hs - h0, 8);
        check("bp_beats_left", exp_req.size(), 0);

        // Address wrap.
        send_vreq(1'b1, 30'h3FFFFFFE, mkvec(32'h77000000, 1), 8'h33, '1);
        wait_vreq_ready(n, 1'b0);
        check("wrap_beats_left", exp_req.size(), 0);

        // Read with duplicate and foreign-tag responses, then a stalled vrsp.
        r.tag = 8'h55; r.vdata = mkvec(32'hC0, 1); exp_rsp.push_back(r);
        bus.vrsp_ready = 1'b0;
        send_vreq(1'b0, 30'h300, '0, 8'h55, '1);
        wait_beats_done();
        for (int i = 0; i < 3; i++) send_rsp(3'(i), 32'hC0 + 32'(i), 8'h55);
        send_rsp(3'd2, 32'hDEAD, 8'h55);
        send_rsp(3'd4, 32'hBAD, 8'h11);
        for (int i = 3; i < 8; i++) send_rsp(3'(i), 32'hC0 + 32'(i), 8'h55);
        repeat (5) begin
            @(negedge clk);
            check("stall_vrsp_valid", bus.vrsp_valid, 1);
            @(posedge clk); #1;
        end
        bus.vrsp_ready = 1'b1;
        wait_rsp_done();

        // Reset after three read beats have been issued.
        h0 = mem_hs;
        send_vreq(1'b0, 30'h400, '0, 8'h77, '1);
        for (int k = 0; k < 100 && (mem_hs - h0) < 3; k++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_beats", mem_hs - h0, 3);
        reset = 1'b1;
        exp_req.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_vreq_ready", bus.vreq_ready, 1);
        check("midrst_mem_req_valid", bus.mem_req_valid, 0);
        check("midrst_mem_req_addr", bus.mem_req_addr, 0);
        check("midrst_vrsp_valid", bus.vrsp_valid, 0);
        @(posedge clk); #1;
        send_rsp(3'd1, 32'hEE, 8'h77);
        send_rsp(3'd0, 32'hEF, 8'h77);
        repeat (3) @(posedge clk);
        #1;
        check("late_rsp_no_vrsp", bus.vrsp_valid, 0);

        r.tag = 8'h78; r.vdata = mkvec(32'hD0, 1); exp_rsp.push_back(r);
        send_vreq(1'b0, 30'h500, '0, 8'h78, '1);
        wait_beats_done();
        for (int i = 0; i < 8; i++) send_rsp(3'(i), 32'hD0 + 32'(i), 8'h78);
        wait_rsp_done();

`ifdef VX_MEM_VSER_BYTEEN_EN
        h0 = mem_hs;
        send_vreq(1'b1, 30'h600, mkvec(32'hE0, 1), 8'h44, 32'h0000000F);
        wait_vreq_ready(n, 1'b0);
        check("byteen_one_beat", mem_hs - h0, 1);
        h0 = mem_hs;
        send_vreq(1'b1, 30'h700, mkvec(32'hF0, 1), 8'h45, 32'h0);
        wait_vreq_ready(n, 1'b0);
        check("byteen_zero_traffic", mem_hs - h0, 0);
`endif

        check("final_req_queue", exp_req.size(), 0);
        check("final_rsp_queue", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
